// File: rtl/wallace_mult_arbiter_8.sv
// Shared 8x8 unsigned multiplier behind a 4-way round-robin arbiter.
// The operands are captured in stage 1. The product is registered in stage 2.
// Stage 2 is released by a ready/valid handshake.
module wallace_unsigned_multiplier_CLA_8 (
  output logic [15:0] product,
  input  logic [7:0]  A,
  input  logic [7:0]  B
);
  logic [15:0] pp [8];
  logic [15:0] l1 [6];
  logic [15:0] l2 [4];
  logic [15:0] l3 [3];
  logic [15:0] fs, fc, g, p;
  logic [15:0] cy;

  function automatic logic [15:0] csa_s(input logic [15:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  // The carry out of bit 15 has weight 2^16. A product of two 8-bit operands
  // never reaches 2^16, so that carry is always zero and can be dropped.
  function automatic logic [15:0] csa_c(input logic [15:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Build the partial products, then reduce them in a Wallace tree (8 -> 6 -> 4 -> 3 -> 2 rows).
  always_comb begin
    for (int i = 0; i < 8; i++)
      pp[i] = B[i] ? ({8'b0, A} << i) : 16'b0;
    l1[0] = csa_s(pp[0], pp[1], pp[2]);
    l1[1] = csa_c(pp[0], pp[1], pp[2]);
    l1[2] = csa_s(pp[3], pp[4], pp[5]);
    l1[3] = csa_c(pp[3], pp[4], pp[5]);
    l1[4] = pp[6];
    l1[5] = pp[7];
    l2[0] = csa_s(l1[0], l1[1], l1[2]);
    l2[1] = csa_c(l1[0], l1[1], l1[2]);
    l2[2] = csa_s(l1[3], l1[4], l1[5]);
    l2[3] = csa_c(l1[3], l1[4], l1[5]);
    l3[0] = csa_s(l2[0], l2[1], l2[2]);
    l3[1] = csa_c(l2[0], l2[1], l2[2]);
    l3[2] = l2[3];
    fs = csa_s(l3[0], l3[1], l3[2]);
    fc = csa_c(l3[0], l3[1], l3[2]);
  end

  // Final carry-propagate adder, written as generate/propagate terms with a carry recurrence.
  always_comb begin
    g = fs & fc;
    p = fs ^ fc;
    cy = 16'b0;
    for (int i = 0; i < 15; i++)
      cy[i+1] = g[i] | (p[i] & cy[i]);
    product = p ^ cy;
  end
endmodule

module wallace_mult_arbiter_8 #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*WIDTH-1:0]      res_product,
  output logic [1:0]              res_id,
  output logic                    busy
);
  logic             op_valid;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_id;
  logic [1:0]       ptr;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic             found;
  logic             s1_accept, s2_accept, grant_any;
  logic [2*WIDTH-1:0] mult_p;

  wallace_unsigned_multiplier_CLA_8 u_mult (
    .product (mult_p),
    .A       (op_a),
    .B       (op_b)
  );

  // Pipeline handshake: stage 2 drains on ready; stage 1 moves when stage 2 can take its content.
  always_comb begin
    s2_accept = !res_valid || res_ready;
    s1_accept = !op_valid || s2_accept;
    busy      = op_valid || res_valid;
    grant_any = |gnt;
  end

  // Round-robin pick: scan upward from ptr; the first requester found wins. No grant while in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    idx     = ptr;
    found   = 1'b0;
    if (!rst && s1_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = ptr + 2'(k);
        if (req[idx] && !found) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx;
        end
      end
    end
  end

  // Stage 1: capture the granted operands and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      ptr      <= '0;
    end else begin
      if (s1_accept)
        op_valid <= grant_any;
      if (grant_any) begin
        op_a  <= a_in[gnt_idx*WIDTH +: WIDTH];
        op_b  <= b_in[gnt_idx*WIDTH +: WIDTH];
        op_id <= gnt_idx;
        ptr   <= gnt_idx + 2'd1;
      end
    end
  end

  // Stage 2: register the product. It holds while the downstream is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_product <= '0;
      res_id      <= '0;
    end else if (s2_accept) begin
      res_valid <= op_valid;
      if (op_valid) begin
        res_product <= mult_p;
        res_id      <= op_id;
      end
    end
  end
endmodule

// File: tb/tb_wallace_mult_arbiter_8.sv
// Directed-vector bench for wallace_mult_arbiter_8.
// Inputs are driven on the falling edge and outputs are sampled 1 time unit later.
module tb_wallace_mult_arbiter_8;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_product;
  logic [1:0]  res_id;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int ngr;

  int exp_gnt  [6] = '{1, 2, 4, 8, 1, 2};
  int exp_prod [4] = '{16830, 9618, 65025, 0};

  wallace_mult_arbiter_8 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .gnt         (gnt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_product (res_product),
    .res_id      (res_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    res_ready = 1'b1;
    a_in      = {8'd0, 8'd255, 8'd229, 8'd98};
    b_in      = {8'd77, 8'd255, 8'd42, 8'd115};

    // Reset state; there must be no grant while rst is high, even with all requests asserted.
    @(negedge clk); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_product", res_product, 0);
    chk("rst_res_id", res_id, 0);

    // Single requester: 98*115
    @(negedge clk); rst = 1'b0; req = 4'b0001; #1;
    chk("single_gnt", gnt, 4'b0001);
    @(negedge clk); req = 4'b0000; #1;
    chk("single_gnt_off", gnt, 0);
    chk("single_busy", busy, 1);
    chk("single_valid_n1", res_valid, 0);
    @(negedge clk); #1;
    chk("single_valid_n2", res_valid, 1);
    chk("single_product", res_product, 11270);
    chk("single_id", res_id, 0);
    @(negedge clk); #1;
    chk("single_drained", res_valid, 0);
    chk("single_idle", busy, 0);

    // All four requesters from reset; full throughput
    @(negedge clk); rst = 1'b1; a_in[7:0] = 8'd170; b_in[7:0] = 8'd99;
    @(negedge clk); rst = 1'b0; req = 4'b1111; res_ready = 1'b1; #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk($sformatf("rr_gnt_c%0d", c), gnt, exp_gnt[c]);
      if (c >= 2) begin
        chk($sformatf("rr_valid_c%0d", c), res_valid, 1);
        chk($sformatf("rr_id_c%0d", c), res_id, c - 2);
        chk($sformatf("rr_product_c%0d", c), res_product, exp_prod[c-2]);
      end else begin
        chk($sformatf("rr_valid_c%0d", c), res_valid, 0);
      end
    end

    // Backpressure: 5 stalled cycles, exactly two grants, product held
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 4'b1111; res_ready = 1'b0; #1;
    ngr = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      ngr += $countones(gnt);
      if (c >= 2) begin
        chk($sformatf("bp_hold_product_c%0d", c), res_product, 16830);
        chk($sformatf("bp_hold_id_c%0d", c), res_id, 0);
        chk($sformatf("bp_hold_valid_c%0d", c), res_valid, 1);
      end
    end
    chk("bp_grant_count", ngr, 2);
    @(negedge clk); req = 4'b0000; res_ready = 1'b1; #1;
    chk("bp_no_gnt_after_drop", gnt, 0);
    chk("bp_drain0_id", res_id, 0);
    chk("bp_drain0_product", res_product, 16830);
    @(negedge clk); #1;
    chk("bp_drain1_valid", res_valid, 1);
    chk("bp_drain1_id", res_id, 1);
    chk("bp_drain1_product", res_product, 9618);
    @(negedge clk); #1;
    chk("bp_drained", res_valid, 0);
    chk("bp_idle", busy, 0);

    // Pointer wrap: ptr is 2 here; the grant to 2 moves it to 3, then 1001 is served as 3 then 0
    @(negedge clk); req = 4'b0100; #1;
    chk("wrap_gnt2", gnt, 4'b0100);
    @(negedge clk); req = 4'b1001; #1;
    chk("wrap_gnt3", gnt, 4'b1000);
    @(negedge clk); req = 4'b0001; #1;
    chk("wrap_gnt0", gnt, 4'b0001);
    chk("wrap_res2_id", res_id, 2);
    chk("wrap_res2_product", res_product, 65025);
    @(negedge clk); req = 4'b0000; #1;
    chk("wrap_res3_id", res_id, 3);
    chk("wrap_res3_product", res_product, 0);
    @(negedge clk); #1;
    chk("wrap_res0_id", res_id, 0);
    chk("wrap_res0_product", res_product, 16830);
    @(negedge clk); #1;
    chk("wrap_idle", busy, 0);

    // Reset while both stages are full
    @(negedge clk); req = 4'b1111; res_ready = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("midrst_pre_valid", res_valid, 1);
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b1; #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_product", res_product, 0);
    @(negedge clk); rst = 1'b0; req = 4'b0000; res_ready = 1'b1; #1;
    chk("postrst_valid0", res_valid, 0);
    @(negedge clk); #1;
    chk("postrst_valid1", res_valid, 0);
    chk("postrst_busy", busy, 0);
    @(negedge clk); req = 4'b0010; #1;
    chk("postrst_first_gnt", gnt, 4'b0010);
    @(negedge clk); req = 4'b0000; #1;
    @(negedge clk); #1;
    chk("postrst_res_valid", res_valid, 1);
    chk("postrst_res_id", res_id, 1);
    chk("postrst_res_product", res_product, 9618);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
